// File: rtl/shift_add_mac_if.sv
// rtl/shift_add_mac_if.sv - request/result bundle for the shift-add multiply-accumulate unit
//
// Purpose: groups the operand request and result signals of shift_add_mac.
// Signals:
//   start    requester -> mac  start request, sampled only while idle
//   a_in     requester -> mac  multiplicand (DATA_WIDTH)
//   b_in     requester -> mac  multiplier (DATA_WIDTH)
//   acc_in   requester -> mac  addend (2*DATA_WIDTH)
//   busy     mac -> requester  operation in progress
//   en_pp    mac -> requester  one-cycle load strobe for the partial-product register
//   outData  mac -> requester  low 2*DATA_WIDTH bits of a*b+acc
//   cout     mac -> requester  carry out of a*b+acc
// Modports: master = requester side, slave = mac side.

interface shift_add_mac_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic                    start;
   logic [DATA_WIDTH-1:0]   a_in;
   logic [DATA_WIDTH-1:0]   b_in;
   logic [2*DATA_WIDTH-1:0] acc_in;
   logic                    busy;
   logic                    en_pp;
   logic [2*DATA_WIDTH-1:0] outData;
   logic                    cout;

   modport master (
      output start, a_in, b_in, acc_in,
      input  busy, en_pp, outData, cout
   );

   modport slave (
      input  start, a_in, b_in, acc_in,
      output busy, en_pp, outData, cout
   );
endinterface

// File: rtl/shift_add_mac.sv
// rtl/shift_add_mac.sv - sequential unsigned shift-add multiply-accumulate
//
// Purpose: computes a_in*b_in + acc_in with one shift-add step per cycle
//   (DATA_WIDTH multiply cycles, one add cycle, one done cycle) and strobes
//   en_pp for one cycle so the downstream partial-product register can load
//   outData/cout.
// Ports:
//   clk    in  clock, all logic on posedge
//   reset  in  synchronous active-high reset, aborts any operation
//   bus    slave modport of shift_add_mac_if (start, a_in, b_in, acc_in,
//          busy, en_pp, outData, cout)

module shift_add_mac #(
   parameter int DATA_WIDTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   shift_add_mac_if.slave  bus
);
   localparam int PW = 2 * DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic [PW-1:0]         mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic [PW-1:0]         addend;
   logic [PW-1:0]         prod;
   logic [CW-1:0]         cnt;
   logic [PW-1:0]         out_r;
   logic                  cout_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start) state_nxt = MULT;
         MULT: if (cnt == CW'(DATA_WIDTH - 1)) state_nxt = ADD;
         ADD:  state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         addend <= '0;
         prod   <= '0;
         cnt    <= '0;
         out_r  <= '0;
         cout_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mcand  <= {{DATA_WIDTH{1'b0}}, bus.a_in};
                  mplier <= bus.b_in;
                  addend <= bus.acc_in;
                  prod   <= '0;
                  cnt    <= '0;
               end
            end
            MULT: begin
               // The multiplicand is pre-widened to PW bits, so the
               // accumulated product cannot overflow.
               if (mplier[0]) prod <= prod + mcand;
               mplier <= mplier >> 1;
               mcand  <= mcand << 1;
               cnt    <= cnt + 1'b1;
            end
            ADD: begin
               {cout_r, out_r} <= {1'b0, prod} + {1'b0, addend};
            end
            default: begin
            end
         endcase
      end
   end

   // outData/cout are only written in ADD, so they stay valid from en_pp
   // until the next operation's ADD cycle.
   assign bus.busy    = (state != IDLE);
   assign bus.en_pp   = (state == DONE);
   assign bus.outData = out_r;
   assign bus.cout    = cout_r;

endmodule

// File: tb/tb_shift_add_mac.sv
// tb/tb_shift_add_mac.sv - scoreboard testbench for shift_add_mac

module tb_shift_add_mac;
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   typedef struct {
      logic [15:0] d;
      logic        c;
      int          due;
   } exp_t;

   exp_t sb[$];

   shift_add_mac_if #(.DATA_WIDTH(8)) bus ();

   shift_add_mac #(.DATA_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every en_pp must match the oldest expected result, on its due cycle.
   always @(negedge clk) begin
      if (!reset && bus.en_pp === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_en_pp: got en_pp=1 at cycle %0d, required none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("outData", 32'(bus.outData), 32'(e.d));
            check("cout", 32'(bus.cout), 32'(e.c));
            check("en_pp_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy === 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy still %0b after %0d cycles, required 0", bus.busy, n);
      end
   endtask

   // Issue one start pulse; the edge after this call samples it. Returns
   // one time unit after that accepting edge with start low and inputs scrambled.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] acc,
                        input logic [15:0] d, input logic c, input bit expect_result);
      exp_t e;
      wait_idle();
      bus.a_in   = a;
      bus.b_in   = b;
      bus.acc_in = acc;
      bus.start  = 1'b1;
      e.d   = d;
      e.c   = c;
      e.due = cyc + 10;
      if (expect_result) sb.push_back(e);
      step();
      bus.start  = 1'b0;
      bus.a_in   = 8'($urandom);
      bus.b_in   = 8'($urandom);
      bus.acc_in = 16'($urandom);
   endtask

   initial begin
      reset      = 1'b1;
      bus.start  = 1'b1;
      bus.a_in   = 8'd1;
      bus.b_in   = 8'd1;
      bus.acc_in = 16'd0;

      // 1: reset with start held high
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_busy", 32'(bus.busy), 32'd0);
         check("rst_en_pp", 32'(bus.en_pp), 32'd0);
         check("rst_outData", 32'(bus.outData), 32'd0);
         check("rst_cout", 32'(bus.cout), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      reset     = 1'b0;
      step();
      check("post_rst_busy", 32'(bus.busy), 32'd0);

      // 2: 3*5+0 with busy window t+1..t+10
      wait_idle();
      bus.a_in   = 8'd3;
      bus.b_in   = 8'd5;
      bus.acc_in = 16'd0;
      bus.start  = 1'b1;
      sb.push_back('{d: 16'h000F, c: 1'b0, due: cyc + 10});
      for (int i = 0; i <= 10; i++) begin
         @(posedge clk);
         if (i == 0) begin
            #1;
            bus.start = 1'b0;
         end
         @(negedge clk);
         check("busy_window", 32'(bus.busy), (i < 10) ? 32'd1 : 32'd0);
      end

      // 3: worst case carry, then plain square
      issue(8'd255, 8'd255, 16'hFFFF, 16'hFE00, 1'b1, 1'b1);
      issue(8'd255, 8'd255, 16'h0000, 16'hFE01, 1'b0, 1'b1);

      // 4: zero multiplicand, second start while busy ignored
      issue(8'd0, 8'hA5, 16'h1234, 16'h1234, 1'b0, 1'b1);
      repeat (3) step();
      bus.start = 1'b1;
      bus.a_in  = 8'd9;
      bus.b_in  = 8'd9;
      step();
      bus.start = 1'b0;
      wait_idle();
      repeat (15) step();
      check("sb_empty_t4", 32'(sb.size()), 32'd0);

      // 5: abort by reset at t+5, then 2*2+1
      issue(8'd7, 8'd9, 16'h0000, 16'h0000, 1'b0, 1'b0);
      repeat (4) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_outData", 32'(bus.outData), 32'd0);
      check("abort_cout", 32'(bus.cout), 32'd0);
      repeat (12) step();
      issue(8'd2, 8'd2, 16'h0001, 16'h0005, 1'b0, 1'b1);
      wait_idle();
      repeat (3) step();

      // 6: start held high, back-to-back operations every 11 cycles
      begin
         int c0;
         c0 = cyc;
         bus.a_in   = 8'd16;
         bus.b_in   = 8'd16;
         bus.acc_in = 16'd0;
         bus.start  = 1'b1;
         for (int k = 0; k < 3; k++)
            sb.push_back('{d: 16'h0100, c: 1'b0, due: c0 + 10 + 11 * k});
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cyc >= c0 + 10) check("stable_outData", 32'(bus.outData), 32'h0100);
            if (i == 25) bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      wait_idle();
      repeat (5) step();
      check("sb_empty_end", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
      $fatal(1);
   end

endmodule
